bus_grant_arbiter: RTL
======================

// Module: bus_grant_arbiter
// PURPOSE
//  Round-robin arbiter that drives the select/enable inputs of the 4-way
//  tri-state bus selector (16-bit busout, 2-bit select s[1:2]).
//  Four requesters compete for the shared bus. One owner holds it for a
//  burst of at most MAX_BURST cycles. An optional dead cycle is inserted
//  between owners so two bus drivers never overlap on the tri net.
// PARAMETERS
//  MAX_BURST   16  max consecutive cycles one owner may hold the bus (>=1)
//  TURNAROUND  1   0: re-arbitrate on release edge; 1: one idle cycle between owners
// PORTS
//  clock    input   1  single clock, rising edge
//  reset    input   1  synchronous, active-high
//  req      input   4  req[i]=1: requester i wants/keeps the bus
//  grant    output  4  one-hot owner, 0 when bus idle
//  s        output  2  [1:2] binary owner index to selector; s[1]=MSB
//  enable   output  1  selector output enable; always == |grant
//  busy     output  1  1 in GRANT or TURNAROUND state
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is synchronous and active-high.
//    All outputs are registered. All state updates happen on the rising edge of clock.
//  - Reset values (on the edge where reset=1 is sampled): state=IDLE, grant=0, s=2'b00,
//    enable=0, busy=0, rr_ptr=0, burst_cnt=0. Reset beats every other
//    event, including reset in the middle of a burst.
//  - States: IDLE, GRANT, TURN.
//  - IDLE: if req!=0 at edge k, pick the first set bit searching
//    rr_ptr, rr_ptr+1 .. (mod 4).
//    After edge k: grant=onehot(w), s=w, enable=1, burst_cnt=1, ->GRANT.
//    Latency req->grant = 1 cycle. If req==0, stay in IDLE with all outputs 0.
//  - GRANT (owner o): changes on non-owner req bits are ignored.
//    Release when req[o]==0 is sampled, or when burst_cnt==MAX_BURST.
//    Both conditions true in the same cycle = one release.
//    If not released: burst_cnt++ (saturating at MAX_BURST).
//    On release: rr_ptr=(o+1) mod 4, grant=0, enable=0.
//      TURNAROUND=1: ->TURN.
//      TURNAROUND=0: arbitrate in the same edge with the new rr_ptr,
//        excluding o, and grant the winner directly (back-to-back owners).
//        If there is no winner, ->IDLE.
//  - TURN: lasts exactly 1 cycle. grant=0, enable=0, busy=1, s holds the old owner.
//    Next edge: same arbitration as IDLE (o may win again if it is the only requester).
//  - s holds its last value whenever enable=0. Only enable gates the bus.
//  - Burst length counts cycles with enable=1. An owner that keeps req high
//    gets exactly MAX_BURST enable cycles.
//  - MAX_BURST=1: every grant lasts one cycle, and owners rotate even under constant requests.
//  - Invariants: $onehot0(grant). enable==|grant. grant!=0 implies s==index(grant).
// TESTING
//  1 reset: hold reset 3 cycles with req=4'hF -> grant=0, enable=0, s=0, busy=0.
//    First grant goes to req0 one cycle after reset drops.
//  2 single: req=4'b0100 at edge k -> grant=0100, s=2, enable=1 after k.
//    Drop req at edge k+3 -> enable=0 after k+3. 3 enable cycles in total.
//  3 rotation: req=4'hF held, MAX_BURST=4, TURNAROUND=1 -> owners 0,1,2,3,0.
//    Each owner gets 4 enable cycles separated by 1 idle cycle.
//  4 no-gap: TURNAROUND=0, req=4'b0011 held, MAX_BURST=2 -> grant 0001,0001,0010,0010,...
//    enable stays 1 continuously.
//  5 simultaneous: the owner drops req in the same cycle its count hits MAX_BURST
//    -> single release, rr_ptr advances by exactly 1.
//  6 mid-reset: assert reset during cycle 2 of a burst -> next edge all outputs 0, rr_ptr=0.

Source files
------------

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_grant_arbiter
// Brief    : Round-robin burst arbiter driving a 4-way tri-state bus selector.
// Revision : 1.0 - initial release
// ============================================================================
module bus_grant_arbiter #(
    parameter int MAX_BURST  = 16,
    parameter int TURNAROUND = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:2] s,
    output logic       enable,
    output logic       busy
);

    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_rr_ptr;
    logic [c_CNT_W-1:0]   r_burst_cnt;

    state_t               w_state_nx;
    logic [3:0]           w_grant_nx;
    logic [1:2]           w_s_nx;
    logic                 w_enable_nx;
    logic                 w_busy_nx;
    logic [1:0]           w_ptr_nx;
    logic [c_CNT_W-1:0]   w_cnt_nx;

    logic [1:0]           w_owner;
    logic                 w_release;
    logic [1:0]           w_arb_ptr;
    logic [3:0]           w_arb_req;
    logic [1:0]           w_cand;
    logic                 w_arb_valid;
    logic [1:0]           w_arb_idx;

    assign w_owner = s;

    // In GRANT the search starts after the current owner and excludes it,
    // which is what back-to-back handover needs; otherwise rr_ptr is used.
    always_comb begin
        w_arb_ptr   = (r_state == ST_GRANT) ? (w_owner + 2'd1) : r_rr_ptr;
        w_arb_req   = (r_state == ST_GRANT) ? (req & ~grant) : req;
        w_arb_valid = 1'b0;
        w_arb_idx   = 2'd0;
        w_cand      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            w_cand = w_arb_ptr + i[1:0];
            if (w_arb_req[w_cand]) begin
                w_arb_valid = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_grant_nx  = grant;
        w_s_nx      = s;
        w_enable_nx = enable;
        w_busy_nx   = busy;
        w_ptr_nx    = r_rr_ptr;
        w_cnt_nx    = r_burst_cnt;
        w_release   = (r_state == ST_GRANT) &&
                      (!req[w_owner] || (r_burst_cnt == c_CNT_W'(MAX_BURST)));

        case (r_state)
            ST_IDLE, ST_TURN: begin
                if (w_arb_valid) begin
                    w_state_nx  = ST_GRANT;
                    w_grant_nx  = 4'b0001 << w_arb_idx;
                    w_s_nx      = w_arb_idx;
                    w_enable_nx = 1'b1;
                    w_busy_nx   = 1'b1;
                    w_cnt_nx    = c_CNT_W'(1);
                end else begin
                    w_state_nx  = ST_IDLE;
                    w_grant_nx  = 4'b0000;
                    w_enable_nx = 1'b0;
                    w_busy_nx   = 1'b0;
                    w_cnt_nx    = '0;
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_cnt_nx = r_burst_cnt + c_CNT_W'(1);
                end else begin
                    w_ptr_nx    = w_owner + 2'd1;
                    w_grant_nx  = 4'b0000;
                    w_enable_nx = 1'b0;
                    w_cnt_nx    = '0;
                    if (TURNAROUND != 0) begin
                        w_state_nx = ST_TURN;
                        w_busy_nx  = 1'b1;
                    end else if (w_arb_valid) begin
                        w_state_nx  = ST_GRANT;
                        w_grant_nx  = 4'b0001 << w_arb_idx;
                        w_s_nx      = w_arb_idx;
                        w_enable_nx = 1'b1;
                        w_busy_nx   = 1'b1;
                        w_cnt_nx    = c_CNT_W'(1);
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_busy_nx  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_grant_nx  = 4'b0000;
                w_enable_nx = 1'b0;
                w_busy_nx   = 1'b0;
                w_cnt_nx    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            grant       <= 4'b0000;
            s           <= 2'b00;
            enable      <= 1'b0;
            busy        <= 1'b0;
            r_rr_ptr    <= 2'd0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            grant       <= w_grant_nx;
            s           <= w_s_nx;
            enable      <= w_enable_nx;
            busy        <= w_busy_nx;
            r_rr_ptr    <= w_ptr_nx;
            r_burst_cnt <= w_cnt_nx;
        end
    end

endmodule
`default_nettype wire
